// File: rtl/datapath.sv
// RV32I integer datapath: program counter, 32x32 register file, immediate
// generator, ALU and write-back multiplexer. All sequencing comes from an
// external multi-cycle controller through the control inputs.
//
// Optional feature, enabled by defining REG_WRITE_GUARD_EN:
//   register-file writes are suppressed for STORE and BRANCH opcodes even
//   when RegWrite=1 and rd!=0. Without it, writes depend only on RegWrite
//   and rd!=0.
module datapath #(
    parameter logic [31:0] INITIAL_PC = 32'h00400000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        PCSrc,
    input  logic        ALUSrc,
    input  logic        RegWrite,
    input  logic        MemToReg,
    input  logic [3:0]  ALUCtrl,
    input  logic        loadPC,
    input  logic [31:0] dReadData,
    output logic [31:0] PC,
    output logic        Zero,
    output logic [31:0] dAddress,
    output logic [31:0] dWriteData,
    output logic [31:0] WriteBackData
);

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SLT = 4'b0100,
        ALU_XOR = 4'b0101,
        ALU_SUB = 4'b0110,
        ALU_SRL = 4'b1000,
        ALU_SLL = 4'b1001,
        ALU_SRA = 4'b1010
    } alu_op_e;

    // Decoded instruction fields
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [6:0]  opcode;
    logic        unused_funct3;

    assign rs1_addr      = instr[19:15];
    assign rs2_addr      = instr[24:20];
    assign rd_addr       = instr[11:7];
    assign opcode        = instr[6:0];
    assign unused_funct3 = ^instr[14:12];

    // State
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];

    // Datapath nets
    logic [31:0] imm;
    logic [31:0] branch_imm;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] alu_b;
    logic [31:0] alu_result;
    logic [31:0] wb_data;
    logic        reg_we;
    alu_op_e     alu_op;

    // Immediate generator: sign-extended immediate selected by opcode
    always_comb begin
        imm = '0;
        unique case (opcode)
            OPC_OP_IMM,
            OPC_LOAD:   imm = {{20{instr[31]}}, instr[31:20]};
            OPC_STORE:  imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OPC_BRANCH: imm = {{19{instr[31]}}, instr[31], instr[7],
                               instr[30:25], instr[11:8], 1'b0};
            default:    imm = '0;
        endcase
    end

    // B-type immediate used for the PC target regardless of opcode
    always_comb begin
        branch_imm = {{19{instr[31]}}, instr[31], instr[7],
                      instr[30:25], instr[11:8], 1'b0};
    end

    // Register-file read ports; x0 is hard-wired to zero
    always_comb begin
        rs1_data = (rs1_addr == 5'd0) ? '0 : regs_q[rs1_addr];
        rs2_data = (rs2_addr == 5'd0) ? '0 : regs_q[rs2_addr];
    end

    // ALU operand B select
    always_comb begin
        alu_b = ALUSrc ? imm : rs2_data;
    end

    assign alu_op = alu_op_e'(ALUCtrl);

    // ALU: unknown operation codes produce zero
    always_comb begin
        alu_result = '0;
        case (alu_op)
            ALU_AND: alu_result = rs1_data & alu_b;
            ALU_OR:  alu_result = rs1_data | alu_b;
            ALU_ADD: alu_result = rs1_data + alu_b;
            ALU_SUB: alu_result = rs1_data - alu_b;
            ALU_SLT: alu_result = {31'b0, ($signed(rs1_data) < $signed(alu_b))};
            ALU_XOR: alu_result = rs1_data ^ alu_b;
            ALU_SRL: alu_result = rs1_data >> alu_b[4:0];
            ALU_SLL: alu_result = rs1_data << alu_b[4:0];
            ALU_SRA: alu_result = $unsigned($signed(rs1_data) >>> alu_b[4:0]);
            default: alu_result = '0;
        endcase
    end

    // Write-back multiplexer
    always_comb begin
        wb_data = MemToReg ? dReadData : alu_result;
    end

    // Register-file write enable, optionally gated for STORE/BRANCH
    always_comb begin
        reg_we = RegWrite && (rd_addr != 5'd0);
`ifdef REG_WRITE_GUARD_EN
        if ((opcode == OPC_STORE) || (opcode == OPC_BRANCH)) begin
            reg_we = 1'b0;
        end
`else
        reg_we = reg_we;
`endif
    end

    // Register-file next state: only the addressed entry changes
    always_comb begin
        regs_d = regs_q;
        if (reg_we) begin
            regs_d[rd_addr] = wb_data;
        end
        regs_d[0] = '0;
    end

    // Register-file storage, cleared by asynchronous reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // PC next state: branch target or sequential, held when loadPC=0
    always_comb begin
        pc_d = pc_q;
        if (loadPC) begin
            pc_d = PCSrc ? (pc_q + branch_imm) : (pc_q + 32'd4);
        end
    end

    // PC register, loaded with INITIAL_PC by asynchronous reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= INITIAL_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign PC            = pc_q;
    assign Zero          = (alu_result == '0);
    assign dAddress      = alu_result;
    assign dWriteData    = rs2_data;
    assign WriteBackData = wb_data;

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: directed steps followed by randomized
// instructions, compared against a behavioural model of the architecture
// (register array, PC value, arithmetic from the instruction-set rules).
module tb_datapath;

    localparam logic [31:0] INIT_PC = 32'h00400000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        PCSrc;
    logic        ALUSrc;
    logic        RegWrite;
    logic        MemToReg;
    logic [3:0]  ALUCtrl;
    logic        loadPC;
    logic [31:0] dReadData;
    logic [31:0] PC;
    logic        Zero;
    logic [31:0] dAddress;
    logic [31:0] dWriteData;
    logic [31:0] WriteBackData;

    datapath #(.INITIAL_PC(INIT_PC)) dut (
        .clk          (clk),
        .rst          (rst),
        .instr        (instr),
        .PCSrc        (PCSrc),
        .ALUSrc       (ALUSrc),
        .RegWrite     (RegWrite),
        .MemToReg     (MemToReg),
        .ALUCtrl      (ALUCtrl),
        .loadPC       (loadPC),
        .dReadData    (dReadData),
        .PC           (PC),
        .Zero         (Zero),
        .dAddress     (dAddress),
        .dWriteData   (dWriteData),
        .WriteBackData(WriteBackData)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_regs [32];
    logic [31:0] m_pc;
    int          n_compared   = 0;
    int          n_mismatched = 0;
    logic [31:0] last_addr;
    logic [31:0] last_wdata;
    logic        last_zero;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input int rd, input int rs1, input int rs2);
        logic [4:0] d, s1, s2;
        d = 5'(rd); s1 = 5'(rs1); s2 = 5'(rs2);
        return {7'b0, s2, s1, 3'b000, d, 7'b0110011};
    endfunction

    function automatic logic [31:0] itype(input logic [11:0] imm, input int rs1, input int rd);
        logic [4:0] d, s1;
        d = 5'(rd); s1 = 5'(rs1);
        return {imm, s1, 3'b000, d, 7'b0010011};
    endfunction

    function automatic logic [31:0] m_imm(input logic [31:0] i);
        logic [11:0] v12;
        logic [12:0] v13;
        case (i[6:0])
            7'b0010011, 7'b0000011: begin v12 = i[31:20]; return 32'($signed(v12)); end
            7'b0100011: begin v12 = {i[31:25], i[11:7]}; return 32'($signed(v12)); end
            7'b1100011: begin
                v13 = {i[31], i[7], i[30:25], i[11:8], 1'b0};
                return 32'($signed(v13));
            end
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] m_bimm(input logic [31:0] i);
        logic [12:0] v13;
        v13 = {i[31], i[7], i[30:25], i[11:8], 1'b0};
        return 32'($signed(v13));
    endfunction

    function automatic logic [31:0] m_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        longint sa, sb;
        sh = int'(b % 32);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return a + b;
            4'd6:  return a - b;
            4'd4:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd5:  return a ^ b;
            4'd8:  return a >> sh;
            4'd9:  return a << sh;
            4'd10: return (a >> sh) | (a[31] ? ~(32'hFFFFFFFF >> sh) : 32'd0);
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit m_guarded(input logic [31:0] i);
`ifdef REG_WRITE_GUARD_EN
        return (i[6:0] == 7'b0100011) || (i[6:0] == 7'b1100011);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_pc = INIT_PC;
        for (int r = 0; r < 32; r++) m_regs[r] = 32'd0;
    endtask

    // One controller step: drive at negedge, check combinational outputs,
    // take the rising edge, update the model, check the new PC.
    task automatic apply(input logic [31:0] ins, input logic pcsrc, input logic alusrc,
                         input logic regwrite, input logic memtoreg, input logic [3:0] aluctrl,
                         input logic loadpc, input logic [31:0] rdata);
        logic [31:0] a, b, res, wb;
        @(negedge clk);
        instr = ins; PCSrc = pcsrc; ALUSrc = alusrc; RegWrite = regwrite;
        MemToReg = memtoreg; ALUCtrl = aluctrl; loadPC = loadpc; dReadData = rdata;
        #1;
        a   = m_regs[ins[19:15]];
        b   = alusrc ? m_imm(ins) : m_regs[ins[24:20]];
        res = m_alu(aluctrl, a, b);
        wb  = memtoreg ? rdata : res;
        check("pc_before", PC, m_pc);
        check("alu_result", dAddress, res);
        check("zero", {31'b0, Zero}, {31'b0, (res == 32'd0)});
        check("wdata", dWriteData, m_regs[ins[24:20]]);
        check("wb_data", WriteBackData, wb);
        last_addr  = dAddress;
        last_wdata = dWriteData;
        last_zero  = Zero;
        @(posedge clk);
        if (regwrite && ins[11:7] != 5'd0 && !m_guarded(ins)) m_regs[ins[11:7]] = wb;
        if (loadpc) m_pc = pcsrc ? m_pc + m_bimm(ins) : m_pc + 32'd4;
        #1;
        check("pc_after", PC, m_pc);
    endtask

    task automatic read_reg(input int r);
        apply(rtype(0, r, 0), 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 32'd0);
    endtask

    // Asynchronous reset asserted away from any clock edge, held across edges
    task automatic mid_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("rst_pc_immediate", PC, INIT_PC);
        loadPC = 1'b1; RegWrite = 1'b1; ALUSrc = 1'b0; ALUCtrl = 4'b0010; MemToReg = 1'b0;
        for (int r = 1; r < 32; r++) begin
            instr = rtype(0, r, 0);
            #2;
            check("rst_reg_zero", dAddress, 32'd0);
        end
        check("rst_pc_hold", PC, INIT_PC);
        @(negedge clk);
        rst = 1'b1; loadPC = 1'b0; RegWrite = 1'b0;
    endtask

    initial begin
        logic [31:0] old_pc, ins;
        logic [6:0]  opc;

        rst = 1'b0; instr = '0; PCSrc = 1'b0; ALUSrc = 1'b0; RegWrite = 1'b0;
        MemToReg = 1'b0; ALUCtrl = '0; loadPC = 1'b0; dReadData = '0;
        model_reset();
        #12;
        check("reset_pc", PC, INIT_PC);
        @(negedge clk);
        rst = 1'b1;

        // ADDI x1,x0,5 with PC advance
        apply(32'h00500093, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0010, 1'b1, 32'd0);
        check("addi_addr", last_addr, 32'd5);
        check("addi_pc", PC, 32'h00400004);
        read_reg(1);
        check("x1_value", last_addr, 32'd5);

        // x2 = -3, then R-type operations
        apply(itype(12'hFFD, 0, 2), 1'b0, 1'b1, 1'b1, 1'b0, 4'b0010, 1'b0, 32'd0);
        apply(rtype(3, 1, 2), 1'b0, 1'b0, 1'b1, 1'b0, 4'b0110, 1'b0, 32'd0);
        check("sub", last_addr, 32'd8);
        apply(rtype(0, 2, 1), 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b0, 32'd0);
        check("slt", last_addr, 32'd1);
        apply(itype(12'd1, 2, 0), 1'b0, 1'b1, 1'b0, 1'b0, 4'b1010, 1'b0, 32'd0);
        check("sra", last_addr, 32'hFFFFFFFE);
        apply(itype(12'd1, 2, 0), 1'b0, 1'b1, 1'b0, 1'b0, 4'b1000, 1'b0, 32'd0);
        check("srl", last_addr, 32'h7FFFFFFE);

        // SW x1,8(x0) and LW x4,8(x0)
        apply(32'h00102423, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b0, 32'd0);
        check("sw_addr", last_addr, 32'd8);
        check("sw_wdata", last_wdata, 32'd5);
        apply({12'd8, 5'd0, 3'b010, 5'd4, 7'b0000011}, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0010, 1'b0, 32'hDEADBEEF);
        read_reg(4);
        check("lw_value", last_addr, 32'hDEADBEEF);

        // BEQ x1,x1,+16 taken and not taken
        old_pc = m_pc;
        apply(32'h00108863, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0110, 1'b1, 32'd0);
        check("beq_zero", {31'b0, last_zero}, 32'd1);
        check("beq_taken_pc", PC, old_pc + 32'd16);
        old_pc = m_pc;
        apply(32'h00108863, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0110, 1'b1, 32'd0);
        check("beq_seq_pc", PC, old_pc + 32'd4);

        // Write to x0 is ignored
        apply(itype(12'd7, 0, 0), 1'b0, 1'b1, 1'b1, 1'b0, 4'b0010, 1'b0, 32'd0);
        read_reg(0);
        check("x0_zero", last_addr, 32'd0);

        // STORE with RegWrite=1 targets instr[11:7] = x8
        apply(32'h00102423, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0010, 1'b0, 32'd0);
        read_reg(8);
`ifdef REG_WRITE_GUARD_EN
        check("store_guard", last_addr, 32'd0);
`else
        check("store_write", last_addr, 32'd8);
`endif

        mid_reset();
        read_reg(1);
        check("x1_after_reset", last_addr, 32'd0);

        // Randomized instructions and control patterns
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 59) == 0) mid_reset();
            case ($urandom_range(0, 5))
                0: opc = 7'b0110011;
                1: opc = 7'b0010011;
                2: opc = 7'b0000011;
                3: opc = 7'b0100011;
                4: opc = 7'b1100011;
                default: opc = 7'($urandom);
            endcase
            ins = {$urandom} & 32'hFFFFFF80;
            ins[6:0] = opc;
            apply(ins, 1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom),
                  4'($urandom), 1'($urandom), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
